// File: rtl/logic_axi4_stream_buffer.sv
// logic_axi4_stream_buffer
// Single-clock AXI4-Stream buffer: circular RAM plus a first-word-fall-through
// output register, fill level with almost-full/almost-empty flags, and an
// optional packet mode that only presents data once a whole packet is stored.
module logic_axi4_stream_buffer #(
  parameter int WIDTH        = 1,
  parameter int CAPACITY     = 256,
  parameter int PACKET_MODE  = 0,
  parameter int ALMOST_FULL  = CAPACITY - 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                          aclk,
  input  logic                          reset,
  input  logic                          rx_tvalid,
  input  logic                          rx_tlast,
  input  logic [WIDTH-1:0]              rx_tdata,
  output logic                          rx_tready,
  output logic                          tx_tvalid,
  output logic                          tx_tlast,
  output logic [WIDTH-1:0]              tx_tdata,
  input  logic                          tx_tready,
  output logic [$clog2(CAPACITY+1)-1:0] level,
  output logic                          almost_full,
  output logic                          almost_empty
);

  // Level/counter width, RAM depth (the output register holds the last beat)
  // and pointer width. DEPTH need not be a power of two.
  localparam int LW    = $clog2(CAPACITY + 1);
  localparam int DEPTH = CAPACITY - 1;
  localparam int PW    = $clog2(DEPTH);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(CAPACITY);
  localparam logic [LW-1:0] AF_LEVEL   = LW'(ALMOST_FULL);
  localparam logic [LW-1:0] AE_LEVEL   = LW'(ALMOST_EMPTY);
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  // Elaboration-time parameter checks.
  if (CAPACITY < 4) begin : g_drc_capacity
    $error("logic_axi4_stream_buffer: CAPACITY must be >= 4");
  end
  if (ALMOST_FULL < 1 || ALMOST_FULL > CAPACITY) begin : g_drc_almost_full
    $error("logic_axi4_stream_buffer: ALMOST_FULL must be in 1..CAPACITY");
  end
  if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > CAPACITY - 1) begin : g_drc_almost_empty
    $error("logic_axi4_stream_buffer: ALMOST_EMPTY must be in 0..CAPACITY-1");
  end

  // Storage: each RAM word is {tlast, tdata}.
  logic [WIDTH:0]   ram_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [LW-1:0]    pkt_q, pkt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             ready_q, ready_d;

  logic [LW-1:0]    ram_count;
  logic             ram_empty;
  logic             wr_en;
  logic             rd_en;
  logic             bypass;
  logic             ram_wr;
  logic             ram_rd;
  logic             wr_last;
  logic             rd_last;

  // Output presentation: plain mode shows the output register whenever it is
  // occupied; packet mode also needs a stored tlast, or a full buffer so that
  // oversize packets still drain.
  always_comb begin
    if (PACKET_MODE != 0) begin
      tx_tvalid = out_valid_q && ((pkt_q != '0) || (level_q == LEVEL_FULL));
    end else begin
      tx_tvalid = out_valid_q;
    end
  end

  // Handshake decode and routing of the incoming beat (bypass vs RAM).
  always_comb begin
    ram_count = level_q - {{(LW-1){1'b0}}, out_valid_q};
    ram_empty = (ram_count == '0);
    wr_en     = rx_tvalid && ready_q;
    rd_en     = tx_tvalid && tx_tready;
    // The output register takes the new beat directly only when nothing older
    // is waiting in RAM and the register is free (or being emptied now).
    bypass    = wr_en && ram_empty && (!out_valid_q || rd_en);
    ram_wr    = wr_en && !bypass;
    ram_rd    = rd_en && !ram_empty;
    wr_last   = wr_en && rx_tlast;
    rd_last   = rd_en && out_last_q;
  end

  // Next-state computation for pointers, output register, level and packets.
  always_comb begin
    // NOTE: every always_comb target is given a default first, so no path
    // leaves a signal unassigned and no latch can be inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    level_d     = level_q;
    pkt_d       = pkt_q;

    if (ram_wr) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (ram_rd) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end

    // The output register only changes when it is free or being read, which
    // keeps tx_tdata/tx_tlast stable during a stalled beat.
    if (bypass) begin
      out_valid_d = 1'b1;
      out_data_d  = rx_tdata;
      out_last_d  = rx_tlast;
    end else if (ram_rd) begin
      out_valid_d = 1'b1;
      {out_last_d, out_data_d} = ram_q[rd_ptr_q];
    end else if (rd_en) begin
      out_valid_d = 1'b0;
    end

    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    case ({wr_last, rd_last})
      2'b10:   pkt_d = pkt_q + LVL_ONE;
      2'b01:   pkt_d = pkt_q - LVL_ONE;
      default: pkt_d = pkt_q;
    endcase
    if (PACKET_MODE == 0) begin
      pkt_d = '0;
    end
  end

  // Ready is registered from the next level so it has no path from tx_tready.
  always_comb begin
    ready_d = (level_d != LEVEL_FULL);
  end

  // Control and output-register state with synchronous reset.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      level_q     <= '0;
      pkt_q       <= '0;
      ready_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      level_q     <= level_d;
      pkt_q       <= pkt_d;
      ready_q     <= ready_d;
    end
  end

  // RAM write port.
  always_ff @(posedge aclk) begin
    // NOTE: the RAM array is deliberately not reset; after reset the pointers
    // and level make every old entry unreachable, and a reset-free array can
    // map onto real RAM.
    if (ram_wr) begin
      ram_q[wr_ptr_q] <= {rx_tlast, rx_tdata};
    end
  end

  assign rx_tready    = ready_q;
  assign tx_tdata     = out_data_q;
  assign tx_tlast     = out_last_q;
  assign level        = level_q;
  assign almost_full  = (level_q >= AF_LEVEL);
  assign almost_empty = (level_q <= AE_LEVEL);

  // The stored beat count can never exceed the capacity.
  a_level_bound : assert property (@(posedge aclk) disable iff (reset)
    level_q <= LEVEL_FULL);

endmodule

// File: tb/tb_logic_axi4_stream_buffer.sv
// Self-checking bench for logic_axi4_stream_buffer: a plain-mode instance
// (CAPACITY=4), a wrap instance (CAPACITY=5) and a packet-mode instance
// (CAPACITY=8), each with a queue scoreboard on its tx side.
module tb_logic_axi4_stream_buffer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- plain instance, CAPACITY=4 ----------------
  logic       p_rx_tvalid, p_rx_tlast, p_rx_tready;
  logic [7:0] p_rx_tdata;
  logic       p_tx_tvalid, p_tx_tlast, p_tx_tready;
  logic [7:0] p_tx_tdata;
  logic [2:0] p_level;
  logic       p_af, p_ae;

  logic_axi4_stream_buffer #(.WIDTH(8), .CAPACITY(4), .PACKET_MODE(0),
                             .ALMOST_FULL(2), .ALMOST_EMPTY(2)) u_plain (
    .aclk(clk), .reset(reset),
    .rx_tvalid(p_rx_tvalid), .rx_tlast(p_rx_tlast), .rx_tdata(p_rx_tdata), .rx_tready(p_rx_tready),
    .tx_tvalid(p_tx_tvalid), .tx_tlast(p_tx_tlast), .tx_tdata(p_tx_tdata), .tx_tready(p_tx_tready),
    .level(p_level), .almost_full(p_af), .almost_empty(p_ae)
  );

  // ---------------- wrap instance, CAPACITY=5 ----------------
  logic       w_rx_tvalid, w_rx_tlast, w_rx_tready;
  logic [7:0] w_rx_tdata;
  logic       w_tx_tvalid, w_tx_tlast, w_tx_tready;
  logic [7:0] w_tx_tdata;
  logic [2:0] w_level;
  logic       w_af, w_ae;

  logic_axi4_stream_buffer #(.WIDTH(8), .CAPACITY(5), .PACKET_MODE(0)) u_wrap (
    .aclk(clk), .reset(reset),
    .rx_tvalid(w_rx_tvalid), .rx_tlast(w_rx_tlast), .rx_tdata(w_rx_tdata), .rx_tready(w_rx_tready),
    .tx_tvalid(w_tx_tvalid), .tx_tlast(w_tx_tlast), .tx_tdata(w_tx_tdata), .tx_tready(w_tx_tready),
    .level(w_level), .almost_full(w_af), .almost_empty(w_ae)
  );

  // ---------------- packet instance, CAPACITY=8 ----------------
  logic       k_rx_tvalid, k_rx_tlast, k_rx_tready;
  logic [7:0] k_rx_tdata;
  logic       k_tx_tvalid, k_tx_tlast, k_tx_tready;
  logic [7:0] k_tx_tdata;
  logic [3:0] k_level;
  logic       k_af, k_ae;

  logic_axi4_stream_buffer #(.WIDTH(8), .CAPACITY(8), .PACKET_MODE(1)) u_pkt (
    .aclk(clk), .reset(reset),
    .rx_tvalid(k_rx_tvalid), .rx_tlast(k_rx_tlast), .rx_tdata(k_rx_tdata), .rx_tready(k_rx_tready),
    .tx_tvalid(k_tx_tvalid), .tx_tlast(k_tx_tlast), .tx_tdata(k_tx_tdata), .tx_tready(k_tx_tready),
    .level(k_level), .almost_full(k_af), .almost_empty(k_ae)
  );

  // ---------------- scoreboards (sampled on the falling edge) ----------------
  logic [8:0] p_q[$], w_q[$], k_q[$];
  logic [8:0] p_e, w_e, k_e;
  int p_sent = 0, p_recv = 0, w_sent = 0, w_recv = 0, k_sent = 0, k_recv = 0;

  always @(negedge clk) begin
    if (reset) begin
      p_q.delete();
    end else begin
      if (p_tx_tvalid && p_tx_tready) begin
        check("p_sb_nonempty", 32'(p_q.size() != 0), 1);
        if (p_q.size() != 0) begin
          p_e = p_q.pop_front();
          check("p_tx_beat", 32'({p_tx_tlast, p_tx_tdata}), 32'(p_e));
        end
        p_recv++;
      end
      if (p_rx_tvalid && p_rx_tready) begin
        p_q.push_back({p_rx_tlast, p_rx_tdata});
        p_sent++;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      w_q.delete();
    end else begin
      if (w_tx_tvalid && w_tx_tready) begin
        check("w_sb_nonempty", 32'(w_q.size() != 0), 1);
        if (w_q.size() != 0) begin
          w_e = w_q.pop_front();
          check("w_tx_beat", 32'({w_tx_tlast, w_tx_tdata}), 32'(w_e));
        end
        w_recv++;
      end
      if (w_rx_tvalid && w_rx_tready) begin
        w_q.push_back({w_rx_tlast, w_rx_tdata});
        w_sent++;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      k_q.delete();
    end else begin
      if (k_tx_tvalid && k_tx_tready) begin
        check("k_sb_nonempty", 32'(k_q.size() != 0), 1);
        if (k_q.size() != 0) begin
          k_e = k_q.pop_front();
          check("k_tx_beat", 32'({k_tx_tlast, k_tx_tdata}), 32'(k_e));
        end
        k_recv++;
      end
      if (k_rx_tvalid && k_rx_tready) begin
        k_q.push_back({k_rx_tlast, k_rx_tdata});
        k_sent++;
      end
    end
  end

  // ---------------- directed table for the plain instance ----------------
  typedef struct {
    logic       rx_tvalid;
    logic [7:0] rx_tdata;
    logic       rx_tlast;
    logic       tx_tready;
    logic       exp_tvalid;
    logic [7:0] exp_tdata;
    logic       exp_tlast;
    logic [2:0] exp_level;
    logic       exp_rx_tready;
    logic       exp_af;
    logic       exp_ae;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int rbase;
    int idx;
    logic [7:0] pkt_data[3];

    //            rxv   data   last  txr  | tv    tdata  tl    lvl   rdy   af    ae
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 8'h66, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    p_rx_tvalid = 1'b0; p_rx_tlast = 1'b0; p_rx_tdata = '0; p_tx_tready = 1'b0;
    w_rx_tvalid = 1'b0; w_rx_tlast = 1'b0; w_rx_tdata = '0; w_tx_tready = 1'b0;
    k_rx_tvalid = 1'b0; k_rx_tlast = 1'b0; k_rx_tdata = '0; k_tx_tready = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_tready", 32'(p_rx_tready), 0);
    check("rst_tx_tvalid", 32'(p_tx_tvalid), 0);
    check("rst_tx_tlast", 32'(p_tx_tlast), 0);
    check("rst_tx_tdata", 32'(p_tx_tdata), 0);
    check("rst_level", 32'(p_level), 0);
    check("rst_almost_full", 32'(p_af), 0);
    check("rst_almost_empty", 32'(p_ae), 1);
    check("rst_k_tx_tvalid", 32'(k_tx_tvalid), 0);
    check("rst_k_level", 32'(k_level), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_release_rx_tready", 32'(p_rx_tready), 1);
    check("rst_release_k_rx_tready", 32'(k_rx_tready), 1);

    // Plain mode: fill to full, blocked write, drain, bypass under read.
    for (int i = 0; i < NV; i++) begin
      p_rx_tvalid = vecs[i].rx_tvalid;
      p_rx_tdata  = vecs[i].rx_tdata;
      p_rx_tlast  = vecs[i].rx_tlast;
      p_tx_tready = vecs[i].tx_tready;
      @(posedge clk); #1;
      check($sformatf("vec%0d_tvalid", i), 32'(p_tx_tvalid), 32'(vecs[i].exp_tvalid));
      if (vecs[i].exp_tvalid) begin
        check($sformatf("vec%0d_tdata", i), 32'(p_tx_tdata), 32'(vecs[i].exp_tdata));
        check($sformatf("vec%0d_tlast", i), 32'(p_tx_tlast), 32'(vecs[i].exp_tlast));
      end
      check($sformatf("vec%0d_level", i), 32'(p_level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d_rx_tready", i), 32'(p_rx_tready), 32'(vecs[i].exp_rx_tready));
      check($sformatf("vec%0d_almost_full", i), 32'(p_af), 32'(vecs[i].exp_af));
      check($sformatf("vec%0d_almost_empty", i), 32'(p_ae), 32'(vecs[i].exp_ae));
    end
    p_rx_tvalid = 1'b0; p_rx_tlast = 1'b0;

    // Streaming: one beat per cycle each way, no bubbles, level stays 1.
    p_tx_tready = 1'b1;
    p_rx_tvalid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      p_rx_tdata = 8'($urandom);
      p_rx_tlast = 1'($urandom);
      @(posedge clk); #1;
      check("stream_tvalid", 32'(p_tx_tvalid), 1);
      check("stream_level", 32'(p_level), 1);
    end
    p_rx_tvalid = 1'b0; p_rx_tlast = 1'b0;
    @(posedge clk); #1;
    check("stream_end_level", 32'(p_level), 0);
    check("stream_end_tvalid", 32'(p_tx_tvalid), 0);

    // Non-power-of-two wrap: random valid/ready in three pressure phases.
    for (int i = 0; i < 300; i++) begin
      idx = (i < 100) ? 3 : ((i < 200) ? 2 : 1);
      w_rx_tvalid = ($urandom_range(0, 3) < idx);
      w_tx_tready = ($urandom_range(0, 3) >= idx);
      w_rx_tdata  = 8'(w_sent);
      w_rx_tlast  = (w_sent % 7 == 6);
      @(posedge clk); #1;
      check("wrap_level", 32'(w_level), w_q.size());
      check("wrap_level_bound", 32'(w_level <= 3'd5), 1);
      check("wrap_rx_tready", 32'(w_rx_tready), 32'(w_q.size() != 5));
      check("wrap_tx_tvalid", 32'(w_tx_tvalid), 32'(w_q.size() != 0));
    end
    w_rx_tvalid = 1'b0; w_tx_tready = 1'b1;
    for (int c = 0; c < 10 && w_level != 0; c++) begin
      @(posedge clk); #1;
    end
    check("wrap_drained", 32'(w_level), 0);
    check("wrap_all_received", w_recv, w_sent);
    w_tx_tready = 1'b0;

    // Packet mode: A,B,C(tlast) held back until C is stored.
    pkt_data[0] = 8'hA1; pkt_data[1] = 8'hB2; pkt_data[2] = 8'hC3;
    k_tx_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      k_rx_tvalid = 1'b1;
      k_rx_tdata  = pkt_data[i];
      k_rx_tlast  = (i == 2);
      @(posedge clk); #1;
      check($sformatf("pkt_hold_tvalid%0d", i), 32'(k_tx_tvalid), 32'(i == 2));
    end
    k_rx_tvalid = 1'b0; k_rx_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pkt_out%0d_tvalid", i), 32'(k_tx_tvalid), 1);
      check($sformatf("pkt_out%0d_tdata", i), 32'(k_tx_tdata), 32'(pkt_data[i]));
      check($sformatf("pkt_out%0d_tlast", i), 32'(k_tx_tlast), 32'(i == 2));
      @(posedge clk); #1;
    end
    check("pkt_done_tvalid", 32'(k_tx_tvalid), 0);
    check("pkt_done_level", 32'(k_level), 0);

    // Packet mode oversize: 8 beats without tlast fill the buffer and release it.
    k_tx_tready = 1'b0;
    base  = k_sent;
    rbase = k_recv;
    for (int c = 0; c < 20 && (k_sent - base) < 8; c++) begin
      k_rx_tvalid = 1'b1;
      k_rx_tdata  = 8'(8'h40 + (k_sent - base));
      k_rx_tlast  = 1'b0;
      @(posedge clk); #1;
      check("ovs_hold_tvalid", 32'(k_tx_tvalid), 32'(k_level == 4'd8));
    end
    k_rx_tdata = 8'(8'h40 + (k_sent - base));
    check("ovs_full_level", 32'(k_level), 8);
    check("ovs_full_rx_tready", 32'(k_rx_tready), 0);
    check("ovs_full_tvalid", 32'(k_tx_tvalid), 1);
    check("ovs_full_tdata", 32'(k_tx_tdata), 32'h40);
    @(posedge clk); #1;
    check("ovs_blocked_level", 32'(k_level), 8);
    // Drain; beats 8 and 9 follow, then a tlast beat releases the tail.
    k_tx_tready = 1'b1;
    for (int c = 0; c < 100 && (k_recv - rbase) < 11; c++) begin
      idx = k_sent - base;
      k_rx_tvalid = (idx < 11);
      k_rx_tdata  = 8'(8'h40 + idx);
      k_rx_tlast  = (idx == 10);
      @(posedge clk); #1;
      check("ovs_level_bound", 32'(k_level <= 4'd8), 1);
    end
    k_rx_tvalid = 1'b0; k_rx_tlast = 1'b0;
    check("ovs_received", k_recv - rbase, 11);
    check("ovs_end_level", 32'(k_level), 0);
    check("ovs_end_tvalid", 32'(k_tx_tvalid), 0);
    k_tx_tready = 1'b0;

    // Reset mid-operation on the plain instance.
    p_tx_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p_rx_tvalid = 1'b1;
      p_rx_tdata  = 8'(8'hE1 + i);
      @(posedge clk); #1;
    end
    check("mid_level_before", 32'(p_level), 3);
    p_rx_tdata = 8'hE4;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_level", 32'(p_level), 0);
    check("mid_rst_tvalid", 32'(p_tx_tvalid), 0);
    check("mid_rst_rx_tready", 32'(p_rx_tready), 0);
    check("mid_rst_tdata", 32'(p_tx_tdata), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_after_rx_tready", 32'(p_rx_tready), 1);
    check("mid_after_tvalid", 32'(p_tx_tvalid), 0);
    check("mid_after_level", 32'(p_level), 0);
    @(posedge clk); #1;
    check("mid_new_tvalid", 32'(p_tx_tvalid), 1);
    check("mid_new_tdata", 32'(p_tx_tdata), 32'hE4);
    p_rx_tvalid = 1'b0;
    p_tx_tready = 1'b1;
    @(posedge clk); #1;
    check("mid_final_level", 32'(p_level), 0);
    check("mid_final_tvalid", 32'(p_tx_tvalid), 0);
    p_tx_tready = 1'b0;

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
